// File: rtl/sort_pkg.sv
// Shared types and constants for the sort/merge stage.
// Holds the default widths, the empty score, the {index, score} entry type,
// the merge FSM state encoding and the head-source encoding used by the
// three-way selector.
package sort_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int INDEX_WIDTH = 16;
  localparam int ENTRY_WIDTH = INDEX_WIDTH + DATA_WIDTH;
  localparam int ENTRIES     = 5;

  localparam logic [DATA_WIDTH-1:0] MIN = 8'h80;

  // One ranked candidate: global index in the upper bits, signed score below.
  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0]  score;
  } entry_t;

  // Merge sequencer: IDLE waits for a batch, Mk produces running entry k.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    M4   = 3'd5
  } merge_state_e;

  // Which list head won a selection.
  typedef enum logic [1:0] {
    SRC_R = 2'd0,
    SRC_L = 2'd1,
    SRC_H = 2'd2
  } src_e;

  // Signed strict greater-than on scores.
  function automatic logic score_gt(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/sort_max3_sel.sv
// Three-head signed maximum selector.
// Picks the highest score among the running-list head (R), the lower-half
// head (L) and the upper-half head (H). Ties go to R, then L, then H. An
// invalid R head never wins; L and H are always valid candidates.
module sort_max3_sel
  import sort_pkg::*;
(
  input  entry_t     r_i,
  input  logic       r_vld_i,
  input  entry_t     l_i,
  input  entry_t     h_i,
  output entry_t     win_o,
  output logic [1:0] src_o
);

  entry_t     best;
  logic [1:0] best_src;

  // Resolve L against H first, then let a valid R take any tie.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    best     = l_i;
    best_src = SRC_L;
    if (score_gt(h_i.score, l_i.score)) begin
      best     = h_i;
      best_src = SRC_H;
    end
    win_o = best;
    src_o = best_src;
    if (r_vld_i && !score_gt(best.score, r_i.score)) begin
      win_o = r_i;
      src_o = SRC_R;
    end
  end

endmodule

// File: rtl/sort_merge_e2.sv
// Second-stage top-5 merger.
// Each accepted batch delivers two descending top-5 lists (upper/lower lane
// halves). Over five cycles M0..M4 they are merged with the running top-5
// of the frame; on the last batch of a frame the merged list is published
// on top_out* with a one-cycle result_valid and the running list is emptied.
// Optional build macro: SORT_MERGE_OVF_EN enables the sticky ovf_err flag
// for strobes that arrive while a merge is in progress.
module sort_merge_e2 #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    INDEX_WIDTH = 16,
  parameter int                    LANES       = 32,
  parameter logic [DATA_WIDTH-1:0] MIN         = 8'h80
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              sorter_clr,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1h_in0,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1h_in1,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1h_in2,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1h_in3,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1h_in4,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1l_in0,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1l_in1,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1l_in2,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1l_in3,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] e1l_in4,
  input  logic                              e1_sort_en,
  input  logic                              e1_last_sort,
  input  logic [INDEX_WIDTH-1:0]            e1_index_counter,
  output logic [INDEX_WIDTH+DATA_WIDTH-1:0] top_out0,
  output logic [INDEX_WIDTH+DATA_WIDTH-1:0] top_out1,
  output logic [INDEX_WIDTH+DATA_WIDTH-1:0] top_out2,
  output logic [INDEX_WIDTH+DATA_WIDTH-1:0] top_out3,
  output logic [INDEX_WIDTH+DATA_WIDTH-1:0] top_out4,
  output logic [4:0]                        top_valid,
  output logic                              result_valid,
  output logic [INDEX_WIDTH-1:0]            result_batches,
  output logic                              busy,
  output logic                              ovf_err
);

  import sort_pkg::*;

  localparam int ENTRY_W = INDEX_WIDTH + DATA_WIDTH;

  // Empty slot of the running list and of the published result.
  localparam entry_t EMPTY = '{index: {INDEX_WIDTH{1'b1}}, score: MIN};

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  merge_state_e state_q, state_d;

  logic       capture;
  logic       merge_en;
  logic       merge_done;
  logic [1:0] merge_slot;

  logic [ENTRY_W-1:0]     l_raw [ENTRIES];
  logic [ENTRY_W-1:0]     h_raw [ENTRIES];
  logic [INDEX_WIDTH-1:0] batch_base;

  entry_t                 cap_l_q [ENTRIES];
  entry_t                 cap_h_q [ENTRIES];
  logic                   cap_last_q;
  logic [INDEX_WIDTH-1:0] cap_cnt_q;

  logic [2:0] r_ptr_q, l_ptr_q, h_ptr_q;

  entry_t               run_q [ENTRIES];
  logic [ENTRIES-1:0]   run_vld_q;
  entry_t               bld_q [ENTRIES-1];
  logic [ENTRIES-2:0]   bld_vld_q;

  entry_t               new_list [ENTRIES];
  logic [ENTRIES-1:0]   new_vld;

  entry_t     r_head, l_head, h_head, win;
  logic       r_head_vld, win_vld;
  logic [1:0] win_src;

  entry_t                 top_q [ENTRIES];
  logic [ENTRIES-1:0]     top_valid_q;
  logic                   result_valid_q;
  logic [INDEX_WIDTH-1:0] result_batches_q;

  // Batches are 1-based, so batch n starts at lane offset LANES*(n-1).
  function automatic entry_t globalize(input logic [ENTRY_W-1:0]     raw,
                                       input logic [INDEX_WIDTH-1:0] base);
    entry_t e;
    e.index = raw[ENTRY_W-1:DATA_WIDTH] + base;
    e.score = raw[DATA_WIDTH-1:0];
    return e;
  endfunction

  assign l_raw[0] = e1l_in0;
  assign l_raw[1] = e1l_in1;
  assign l_raw[2] = e1l_in2;
  assign l_raw[3] = e1l_in3;
  assign l_raw[4] = e1l_in4;
  assign h_raw[0] = e1h_in0;
  assign h_raw[1] = e1h_in1;
  assign h_raw[2] = e1h_in2;
  assign h_raw[3] = e1h_in3;
  assign h_raw[4] = e1h_in4;

  assign batch_base = INDEX_WIDTH'(LANES) * (e1_index_counter - INDEX_WIDTH'(1));

  // ---------------------------------------------------------------------
  // Merge FSM
  // ---------------------------------------------------------------------

  // State register; reset and sorter_clr both force IDLE.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (!sys_rst_n || sorter_clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start on a strobe in IDLE, then one merge step per cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (e1_sort_en) state_d = M0;
      M0:      state_d = M1;
      M1:      state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = M4;
      M4:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: capture strobe, merge slot, last-step flag and busy.
  always_comb begin
    busy       = (state_q != IDLE);
    capture    = (state_q == IDLE) && e1_sort_en;
    merge_en   = 1'b0;
    merge_done = 1'b0;
    merge_slot = 2'd0;
    case (state_q)
      M0: begin merge_en = 1'b1; merge_slot = 2'd0; end
      M1: begin merge_en = 1'b1; merge_slot = 2'd1; end
      M2: begin merge_en = 1'b1; merge_slot = 2'd2; end
      M3: begin merge_en = 1'b1; merge_slot = 2'd3; end
      M4: begin merge_en = 1'b1; merge_done = 1'b1; end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Merge datapath
  // ---------------------------------------------------------------------

  // Pointers never pass 4 while selecting: at most four picks precede M4.
  assign r_head     = run_q[r_ptr_q];
  assign r_head_vld = run_vld_q[r_ptr_q];
  assign l_head     = cap_l_q[l_ptr_q];
  assign h_head     = cap_h_q[h_ptr_q];

  sort_max3_sel u_sel (
    .r_i     (r_head),
    .r_vld_i (r_head_vld),
    .l_i     (l_head),
    .h_i     (h_head),
    .win_o   (win),
    .src_o   (win_src)
  );

  assign win_vld = (win_src != SRC_R) || r_head_vld;

  // New running list: entries 0..3 already built, entry 4 is this cycle's pick.
  always_comb begin
    for (int i = 0; i < ENTRIES - 1; i++) begin
      new_list[i] = bld_q[i];
      new_vld[i]  = bld_vld_q[i];
    end
    new_list[ENTRIES-1] = win;
    new_vld[ENTRIES-1]  = win_vld;
  end

  // Batch capture, head pointers and the list under construction.
  always_ff @(posedge sys_clk) begin
    // NOTE: these arrays carry no reset: they are fully written by a capture
    // or a merge step before anything reads them, so a reset adds only muxes.
    if (capture) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cap_l_q[i] <= globalize(l_raw[i], batch_base);
        cap_h_q[i] <= globalize(h_raw[i], batch_base);
      end
      cap_last_q <= e1_last_sort;
      cap_cnt_q  <= e1_index_counter;
      r_ptr_q    <= 3'd0;
      l_ptr_q    <= 3'd0;
      h_ptr_q    <= 3'd0;
    end else if (merge_en) begin
      if (!merge_done) begin
        bld_q[merge_slot]     <= win;
        bld_vld_q[merge_slot] <= win_vld;
      end
      case (win_src)
        SRC_R:   r_ptr_q <= r_ptr_q + 3'd1;
        SRC_L:   l_ptr_q <= l_ptr_q + 3'd1;
        default: h_ptr_q <= h_ptr_q + 3'd1;
      endcase
    end
  end

  // Running list swap and result publication at the M4 edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || sorter_clr) begin
      for (int i = 0; i < ENTRIES; i++) begin
        run_q[i] <= EMPTY;
        top_q[i] <= EMPTY;
      end
      run_vld_q        <= '0;
      top_valid_q      <= '0;
      result_valid_q   <= 1'b0;
      result_batches_q <= '0;
    end else begin
      result_valid_q <= 1'b0;
      if (merge_done) begin
        if (cap_last_q) begin
          for (int i = 0; i < ENTRIES; i++) begin
            top_q[i] <= new_list[i];
            run_q[i] <= EMPTY;
          end
          top_valid_q      <= new_vld;
          result_batches_q <= cap_cnt_q;
          result_valid_q   <= 1'b1;
          run_vld_q        <= '0;
        end else begin
          for (int i = 0; i < ENTRIES; i++) begin
            run_q[i] <= new_list[i];
          end
          run_vld_q <= new_vld;
        end
      end
    end
  end

  assign top_out0       = top_q[0];
  assign top_out1       = top_q[1];
  assign top_out2       = top_q[2];
  assign top_out3       = top_q[3];
  assign top_out4       = top_q[4];
  assign top_valid      = top_valid_q;
  assign result_valid   = result_valid_q;
  assign result_batches = result_batches_q;

  // ---------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------
`ifdef SORT_MERGE_OVF_EN
  logic ovf_q;

  // Sticky: a strobe that lands while busy is dropped and remembered here.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || sorter_clr) begin
      ovf_q <= 1'b0;
    end else if (e1_sort_en && busy) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule
